// File: rtl/bcd2_down_timer.sv
// Two-digit BCD countdown timer (00-99) with load, start/resume, pause and a
// one-cycle done pulse on reaching 00. All outputs are registered.
module bcd2_down_timer #(
    parameter logic TICK_ACTIVE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state;
    logic   tick_q;
    logic   count_zero;

    assign tick_q     = (tick == TICK_ACTIVE);
    assign count_zero = (tens == 4'd0) && (ones == 4'd0);

    // Loaded digits above 9 clamp to 9 so the display path only ever sees BCD.
    function automatic logic [3:0] sat9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tens  <= 4'd0;
            ones  <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        tens <= sat9(load_tens);
                        ones <= sat9(load_ones);
                    end else if (start) begin
                        if (count_zero) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // load is ignored here; pause outranks tick and drops it.
                    if (pause) begin
                        state <= S_PAUSED;
                    end else if (tick_q) begin
                        if (ones != 4'd0) begin
                            ones <= ones - 4'd1;
                            if ((tens == 4'd0) && (ones == 4'd1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (tens != 4'd0) begin
                            ones <= 4'd9;
                            tens <= tens - 4'd1;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (load) begin
                        tens  <= sat9(load_tens);
                        ones  <= sat9(load_ones);
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (load) begin
                        tens  <= sat9(load_tens);
                        ones  <= sat9(load_ones);
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2_down_timer.sv
// Bench for bcd2_down_timer: directed scenarios then random traffic, every
// cycle compared against an integer-count reference model.
module tb_bcd2_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Reference model: count held as a plain integer 0..99 plus an activity mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_count = 0;
    int m_mode  = M_IDLE;
    int m_done  = 0;

    always #5 clk = ~clk;

    bcd2_down_timer #(.TICK_ACTIVE(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_tens(load_tens),
        .load_ones(load_ones),
        .start    (start),
        .pause    (pause),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_update(input bit r, input bit l, input int lt, input int lo,
                                input bit s, input bit p, input bit t);
        m_done = 0;
        if (r) begin
            m_count = 0;
            m_mode  = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (l) m_count = clamp9(lt) * 10 + clamp9(lo);
            else if (s) begin
                if (m_count == 0) begin m_mode = M_DONE; m_done = 1; end
                else m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (p) m_mode = M_PAUSED;
            else if (t) begin
                if (m_count > 0) m_count = m_count - 1;
                if (m_count == 0) begin m_mode = M_DONE; m_done = 1; end
            end
        end else if (m_mode == M_PAUSED) begin
            if (l) begin m_count = clamp9(lt) * 10 + clamp9(lo); m_mode = M_IDLE; end
            else if (s) m_mode = M_RUN;
        end else begin
            if (l) begin m_count = clamp9(lt) * 10 + clamp9(lo); m_mode = M_IDLE; end
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, compare 1 time unit later.
    task automatic step(input bit r, input bit l, input int lt, input int lo,
                        input bit s, input bit p, input bit t, input string tag);
        rst = r; load = l; load_tens = 4'(lt); load_ones = 4'(lo);
        start = s; pause = p; tick = t;
        @(posedge clk);
        model_update(r, l, lt, lo, s, p, t);
        #1;
        check({tag, ".tens"}, int'(tens), m_count / 10);
        check({tag, ".ones"}, int'(ones), m_count % 10);
        check({tag, ".busy"}, int'(busy), (m_mode == M_RUN || m_mode == M_PAUSED) ? 1 : 0);
        check({tag, ".done"}, int'(done), m_done);
    endtask

    task automatic do_load(input int lt, input int lo);
        step(0, 1, lt, lo, 0, 0, 0, "load");
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, "tick");
    endtask

    initial begin
        int pulses;

        // Reset beats a simultaneous load.
        step(1, 1, 5, 5, 0, 0, 0, "rst_load");
        step(1, 1, 5, 5, 0, 0, 0, "rst_load");
        check("rst_tens_zero", int'(tens), 0);

        // Full countdown from 23 with exactly one done pulse.
        do_load(2, 3);
        step(0, 0, 0, 0, 1, 0, 0, "start23");
        pulses = 0;
        for (int i = 0; i < 26; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, "run23");
            pulses += int'(done);
        end
        check("run23_pulses", pulses, 1);
        check("run23_final_ones", int'(ones), 0);

        // Borrow from 10, then saturation of out-of-range digits.
        do_load(1, 0);
        step(0, 0, 0, 0, 1, 0, 0, "start10");
        do_tick(1);
        check("borrow_ones", int'(ones), 9);
        check("borrow_tens", int'(tens), 0);
        step(0, 0, 0, 0, 0, 1, 0, "pause09");
        do_load(12, 15);
        check("sat_tens", int'(tens), 9);
        check("sat_ones", int'(ones), 9);

        // Pause drops a same-cycle tick; ticks while paused are ignored.
        do_load(4, 7);
        step(0, 0, 0, 0, 1, 0, 0, "start47");
        step(0, 0, 0, 0, 0, 1, 1, "pause_tick");
        check("pause_hold_ones", int'(ones), 7);
        do_tick(3);
        step(0, 0, 0, 0, 1, 0, 0, "resume");
        do_tick(1);
        check("resume_ones", int'(ones), 6);

        // Start at 00 goes straight to DONE.
        step(0, 0, 0, 0, 0, 1, 0, "pause46");
        do_load(0, 0);
        step(0, 0, 0, 0, 1, 0, 0, "start00");
        check("start00_done", int'(done), 1);
        step(0, 0, 0, 0, 0, 0, 1, "after00");

        // Load while running is ignored and counting continues.
        do_load(3, 0);
        step(0, 0, 0, 0, 1, 0, 0, "start30");
        do_tick(1);
        step(0, 1, 9, 9, 0, 0, 1, "load_in_run");
        check("load_in_run_val", int'(tens) * 10 + int'(ones), 28);

        // Reset mid-run aborts with no done pulse.
        step(0, 0, 0, 0, 0, 1, 0, "pause28");
        do_load(1, 2);
        step(0, 0, 0, 0, 1, 0, 0, "start12");
        do_tick(1);
        step(1, 0, 0, 0, 0, 0, 1, "rst_mid");
        do_tick(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, l, s, p, t;
            int lt, lo;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 15) == 0);
            p  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 1) == 1);
            lt = int'($urandom_range(0, 15));
            lo = int'($urandom_range(0, 15));
            step(r, l, lt, lo, s, p, t, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
